// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Canonical bubble: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are discarded.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs between the
// instruction memory response and the IF/ID register. DEPTH must be a power
// of two so the pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  fetch_entry_t                 i_push_data,
    input  logic                         i_pop,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok;
    logic               pop_ok;

    assign o_empty = (count_q == CNT_W'(0));
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    // Qualify push/pop against occupancy; a push into a full queue is only legal with a pop.
    always_comb begin
        push_ok = i_push && (!o_full || i_pop);
        pop_ok  = i_pop && !o_empty;
    end

    // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; data needs no reset because occupancy gates its visibility.
    always_ff @(posedge i_clk) begin
        if (push_ok && !i_clear) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, issues in-order requests to instruction memory,
// buffers responses in fetch_queue and presents {instr, pc, pc_four} to IF/ID.
// Redirects discard stale in-flight fetches by counting them into a drop
// counter; responses arriving while that counter is non-zero are thrown away.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetched/bubble counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FQ_DEPTH        = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        StallD,
    output logic        o_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_four
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_cnt_fetched,
    output logic [31:0] o_cnt_bubble
`endif
);

    localparam int          OUT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam int          CNT_W       = $clog2(FQ_DEPTH + 1);
    localparam logic [31:0] FQ_DEPTH_W  = 32'(FQ_DEPTH);
    localparam logic [31:0] MAX_OUT_W   = 32'(MAX_OUTSTANDING);

    logic [31:0]      req_pc_q, req_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [OUT_W-1:0] live_q,   live_d;
    logic [OUT_W-1:0] drop_q,   drop_d;

    logic             issue_ok;
    logic             accept;
    logic             rsp_push;
    logic             rsp_discard;
    logic             pop;
    logic [31:0]      redirect_pc_al;
    logic [OUT_W-1:0] inflight;

    fetch_entry_t     fq_head;
    fetch_entry_t     fq_push_data;
    logic [CNT_W-1:0] fq_count;
    logic             fq_empty;
    logic             fq_full;
    logic             fq_push;

    // Issue / response / pop decisions for this cycle.
    always_comb begin
        redirect_pc_al = word_align(i_redirect_pc);
        inflight       = live_q + drop_q;
        issue_ok       = ((32'(live_q) + 32'(fq_count)) < FQ_DEPTH_W) &&
                         (32'(inflight) < MAX_OUT_W);
        o_imem_req_valid = !i_rst && !i_redirect && issue_ok;
        o_imem_req_addr  = req_pc_q;
        accept         = o_imem_req_valid && i_imem_req_ready;
        rsp_discard    = i_imem_rsp_valid && (i_redirect || (drop_q != OUT_W'(0)));
        rsp_push       = i_imem_rsp_valid && !rsp_discard;
        o_valid        = !fq_empty;
        pop            = o_valid && !StallD && !i_redirect;
        fq_push        = rsp_push && (!fq_full || pop);
        fq_push_data   = '{pc: rsp_pc_q, instr: i_imem_rsp_data};
    end

    // Next-state for PCs and the live/drop credit counters.
    always_comb begin
        req_pc_d = req_pc_q;
        rsp_pc_d = rsp_pc_q;
        live_d   = live_q;
        drop_d   = drop_q;
        if (i_redirect) begin
            // Everything still in flight becomes stale; a response landing now is one of them.
            req_pc_d = redirect_pc_al;
            rsp_pc_d = redirect_pc_al;
            live_d   = OUT_W'(0);
            if (i_imem_rsp_valid && (inflight != OUT_W'(0))) begin
                drop_d = inflight - OUT_W'(1);
            end else begin
                drop_d = inflight;
            end
        end else begin
            if (accept) begin
                req_pc_d = req_pc_q + 32'd4;
            end else begin
                req_pc_d = req_pc_q;
            end
            if (rsp_push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end else begin
                rsp_pc_d = rsp_pc_q;
            end
            live_d = live_q + (accept   ? OUT_W'(1) : OUT_W'(0))
                            - (rsp_push ? OUT_W'(1) : OUT_W'(0));
            if (rsp_discard) begin
                drop_d = drop_q - OUT_W'(1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // PC and credit state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            live_q   <= OUT_W'(0);
            drop_q   <= OUT_W'(0);
        end else begin
            req_pc_q <= req_pc_d;
            rsp_pc_q <= rsp_pc_d;
            live_q   <= live_d;
            drop_q   <= drop_d;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (i_redirect),
        .i_push      (fq_push),
        .i_push_data (fq_push_data),
        .i_pop       (pop),
        .o_head      (fq_head),
        .o_count     (fq_count),
        .o_empty     (fq_empty),
        .o_full      (fq_full)
    );

    // Present queue head to IF/ID, or a NOP bubble when nothing is buffered.
    always_comb begin
        instr   = NOP_INSTR;
        pc      = 32'h0000_0000;
        pc_four = 32'h0000_0000;
        if (o_valid) begin
            instr   = fq_head.instr;
            pc      = fq_head.pc;
            pc_four = fq_head.pc + 32'd4;
        end else begin
            instr   = NOP_INSTR;
            pc      = 32'h0000_0000;
            pc_four = 32'h0000_0000;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_fetched_q;
    logic [31:0] cnt_bubble_q;

    // Performance counters: instructions handed to IF/ID and empty unstalled cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_fetched_q <= 32'd0;
            cnt_bubble_q  <= 32'd0;
        end else begin
            if (pop) begin
                cnt_fetched_q <= cnt_fetched_q + 32'd1;
            end
            if (!o_valid && !StallD) begin
                cnt_bubble_q <= cnt_bubble_q + 32'd1;
            end
        end
    end

    assign o_cnt_fetched = cnt_fetched_q;
    assign o_cnt_bubble  = cnt_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. The bench owns an instruction memory
// model (in-order, per-request latency) that tags each accepted request with
// the fetch "epoch" current at issue; a redirect starts a new epoch, so stale
// responses are recognised by tag rather than by counting. A reference queue
// of {pc, instr} predicts IF/ID outputs cycle by cycle.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          FQ_DEPTH  = 2;
    localparam int          MAX_OUT   = 2;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk;
    logic        i_rst;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        StallD;
    logic        o_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_four;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_cnt_fetched;
    logic [31:0] o_cnt_bubble;
`endif

    fetch_stage #(
        .RESET_PC        (RESET_PC),
        .FQ_DEPTH        (FQ_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .StallD           (StallD),
        .o_valid          (o_valid),
        .instr            (instr),
        .pc               (pc),
        .pc_four          (pc_four)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_cnt_fetched    (o_cnt_fetched),
        .o_cnt_bubble     (o_cnt_bubble)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ref_ent_t;

    mem_req_t    mem_q[$];
    ref_ent_t    ref_q[$];
    int          epoch;
    int          cyc;
    logic [31:0] exp_req_pc;
    logic [31:0] exp_fetched;
    logic [31:0] exp_bubble;

    // stimulus knobs
    logic        rst_v;
    logic        ready_v;
    logic        redir_v;
    logic [31:0] redir_pc_v;
    logic        stall_v;
    int          lat;

    int checks;
    int errors;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the reference, advance reference.
    task automatic step();
        logic        rsp;
        logic        exp_rv;
        logic        exp_ov;
        logic        do_pop;
        int          live;
        mem_req_t    h;
        ref_ent_t    e;
        @(negedge clk);
        rsp = 1'b0;
        if (!rst_v && mem_q.size() > 0 && mem_q[0].due <= cyc) rsp = 1'b1;
        i_rst            = rst_v;
        i_imem_req_ready = ready_v;
        i_redirect       = redir_v;
        i_redirect_pc    = redir_pc_v;
        StallD           = stall_v;
        i_imem_rsp_valid = rsp;
        i_imem_rsp_data  = rsp ? instr_of(mem_q[0].addr) : 32'h0000_0000;
        #1;
        if (rst_v) begin
            chk("req_valid_in_reset", {31'd0, o_imem_req_valid}, 32'd0);
            mem_q.delete();
            ref_q.delete();
            epoch++;
            exp_req_pc  = RESET_PC;
            exp_fetched = 32'd0;
            exp_bubble  = 32'd0;
        end else begin
            live = 0;
            foreach (mem_q[k]) if (mem_q[k].epoch == epoch) live++;
            exp_rv = !redir_v && ((live + ref_q.size()) < FQ_DEPTH) && (mem_q.size() < MAX_OUT);
            exp_ov = (ref_q.size() > 0);
            chk("req_valid", {31'd0, o_imem_req_valid}, {31'd0, exp_rv});
            if (exp_rv) chk("req_addr", o_imem_req_addr, exp_req_pc);
            chk("o_valid", {31'd0, o_valid}, {31'd0, exp_ov});
            if (exp_ov) begin
                chk("pc", pc, ref_q[0].pc);
                chk("instr", instr, ref_q[0].ins);
                chk("pc_four", pc_four, ref_q[0].pc + 32'd4);
            end else begin
                chk("bubble_instr", instr, NOP);
                chk("bubble_pc", pc, 32'd0);
                chk("bubble_pc_four", pc_four, 32'd0);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("cnt_fetched", o_cnt_fetched, exp_fetched);
            chk("cnt_bubble", o_cnt_bubble, exp_bubble);
`endif
            do_pop = exp_ov && !stall_v && !redir_v;
            if (do_pop) void'(ref_q.pop_front());
            if (rsp) begin
                h = mem_q.pop_front();
                if (!redir_v && h.epoch == epoch) begin
                    e.pc  = h.addr;
                    e.ins = instr_of(h.addr);
                    ref_q.push_back(e);
                end
            end
            if (exp_rv && ready_v) begin
                mem_q.push_back('{exp_req_pc, epoch, cyc + lat});
                exp_req_pc = exp_req_pc + 32'd4;
            end
            if (redir_v) begin
                ref_q.delete();
                epoch++;
                exp_req_pc = redir_pc_v & 32'hFFFF_FFFC;
            end
            if (do_pop) exp_fetched = exp_fetched + 32'd1;
            if (!exp_ov && !stall_v) exp_bubble = exp_bubble + 32'd1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_v   = 1'b1;
        redir_v = 1'b0;
        stall_v = 1'b0;
        step();
        step();
        rst_v = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; epoch = 0; cyc = 0;
        exp_req_pc = RESET_PC; exp_fetched = 32'd0; exp_bubble = 32'd0;
        rst_v = 1'b1; ready_v = 1'b1; redir_v = 1'b0; redir_pc_v = 32'd0;
        stall_v = 1'b0; lat = 1;
        i_rst = 1'b1; i_imem_req_ready = 1'b1; i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data = 32'd0; i_redirect = 1'b0; i_redirect_pc = 32'd0; StallD = 1'b0;

        // Test 1: straight-line fetch, 1-cycle memory
        do_reset();
        step();                                              // c0: request 0x0
        chk("t1_first_req_addr", o_imem_req_addr, 32'h0000_0000);
        chk("t1_c0_valid", {31'd0, o_valid}, 32'd0);
        step();                                              // c1: response for 0x0
        chk("t1_c1_nop", instr, 32'h0000_0013);
        step();                                              // c2: first instruction visible
        chk("t1_c2_valid", {31'd0, o_valid}, 32'd1);
        chk("t1_c2_pc", pc, 32'h0000_0000);
        chk("t1_c2_pc4", pc_four, 32'h0000_0004);
        chk("t1_c2_instr", instr, 32'hA5A5_0001);
        step();
        chk("t1_c3_pc", pc, 32'h0000_0004);
        chk("t1_c3_pc4", pc_four, 32'h0000_0008);

        // Test 2: hold IF/ID for 4 cycles; queue fills and requests stop
        stall_v = 1'b1;
        repeat (4) step();
        chk("t2_req_blocked", {31'd0, o_imem_req_valid}, 32'd0);
        chk("t2_held_valid", {31'd0, o_valid}, 32'd1);
        chk("t2_held_pc", pc, 32'h0000_0008);
        stall_v = 1'b0;
        repeat (8) step();

        // Test 3: two outstanding at 3-cycle latency, then redirect to 0x100
        lat = 3;
        n = 0;
        while (mem_q.size() < 2 && n < 20) begin step(); n++; end
        chk("t3_two_outstanding", 32'(mem_q.size()), 32'd2);
        redir_v = 1'b1; redir_pc_v = 32'h0000_0100;
        step();
        redir_v = 1'b0;
        n = 0;
        do begin step(); n++; end while (!o_valid && n < 30);
        chk("t3_first_pc", pc, 32'h0000_0100);
        chk("t3_first_instr", instr, 32'hA5A5_0101);
        repeat (4) step();

        // Test 4: redirect coinciding with a response and req_ready
        lat = 1;
        n = 0;
        while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && n < 20) begin step(); n++; end
        redir_v = 1'b1; redir_pc_v = 32'h0000_0100;
        step();
        chk("t4_no_req_on_redirect", {31'd0, o_imem_req_valid}, 32'd0);
        chk("t4_rsp_present", {31'd0, i_imem_rsp_valid}, 32'd1);
        redir_v = 1'b0;
        n = 0;
        do begin step(); n++; end while (!o_imem_req_valid && n < 10);
        chk("t4_next_req_addr", o_imem_req_addr, 32'h0000_0100);
        repeat (4) step();

        // Test 5: back-pressure holds address; redirect to top of memory wraps
        ready_v = 1'b0;
        repeat (8) step();
        redir_v = 1'b1; redir_pc_v = 32'h0000_0200;
        step();
        redir_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold_valid", {31'd0, o_imem_req_valid}, 32'd1);
            chk("t5_hold_addr", o_imem_req_addr, 32'h0000_0200);
        end
        redir_v = 1'b1; redir_pc_v = 32'hFFFF_FFFF;
        step();
        redir_v = 1'b0; ready_v = 1'b1;
        step();
        chk("t5_top_addr", o_imem_req_addr, 32'hFFFF_FFFC);
        step();
        chk("t5_wrap_addr", o_imem_req_addr, 32'h0000_0000);
        repeat (4) step();

        // Mixed traffic: back-pressure, stalls, varying latency, back-to-back redirects
        for (int i = 0; i < 80; i++) begin
            ready_v    = (i % 3) != 2;
            stall_v    = ((i % 5) == 4) || ((i % 7) == 0);
            lat        = ((i % 4) == 0) ? 3 : 1;
            redir_v    = (i == 30) || (i == 31) || (i == 55);
            redir_pc_v = 32'h0000_1000 + 32'(i) * 32'd16;
            step();
        end
        redir_v = 1'b0; stall_v = 1'b0; ready_v = 1'b1; lat = 1;
        repeat (6) step();

        // Reset in the middle of traffic, then restart from RESET_PC
        repeat (1) step();
        do_reset();
        n = 0;
        do begin step(); n++; end while (!o_valid && n < 10);
        chk("rst_restart_pc", pc, 32'h0000_0000);

`ifdef FETCH_PERF_CNT_EN
        // Test 6: 5 pops and 3 bubble cycles from a fresh reset
        do_reset();
        step(); step();                                       // c0,c1: bubbles
        chk("t6_cnt_after_reset", o_cnt_fetched, 32'd0);
        stall_v = 1'b1; repeat (4) step();                    // c2..c5
        stall_v = 1'b0; repeat (5) step();                    // c6..c10
        stall_v = 1'b1; repeat (2) step();                    // c11,c12
        stall_v = 1'b0; step();                               // c13
        step();
        chk("t6_fetched", o_cnt_fetched, 32'd5);
        chk("t6_bubble", o_cnt_bubble, 32'd3);
        do_reset();
        step();
        chk("t6_fetched_reset", o_cnt_fetched, 32'd0);
        chk("t6_bubble_reset", o_cnt_bubble, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
